taint_arbiter: RTL

Two-requester arbiter and sequencer for the ALU operand taint-propagation path. Each requester presents a 64-bit operand dword (two 32-bit operands, bit 63 and bit 31 are the taint flags). The block grants one requester per cycle round-robin, applies the taint rule, registers the result in a single-entry output stage with valid/ready handshake, and counts tainted transactions. It sits between the operand-fetch requesters and the ALU input port.

---
 rtl/taint_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/taint_arbiter.sv
// Two-requester round-robin arbiter feeding a single-entry taint-processing output stage.
// Optional build macro TAINT_STICKY_EN: per-requester sticky taint, cleared only by rst.
module taint_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      i0,
    input  logic             v0,
    output logic             r0,
    input  logic [63:0]      i1,
    input  logic             v1,
    output logic             r1,
    output logic [63:0]      o,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_src,
    output logic             o_taint,
    output logic [CNT_W-1:0] taint_cnt
);

    localparam logic [63:0] KEEP_MASK  = 64'h7FFFFFFF7FFFFFFF;
    localparam logic [63:0] FORCE_BITS = 64'h8000000080000000;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state_reg;
    logic        pri_reg;
    logic        grant;
    logic        can_accept;
    logic        accept;
    logic        sticky_hit;
    logic        tainted;
    logic [63:0] sel;
    logic [63:0] result;

    // With both valid the favored requester wins; otherwise the lone valid one does.
    always_comb begin
        grant = pri_reg;
        if (v0 && !v1) begin
            grant = 1'b0;
        end else if (v1 && !v0) begin
            grant = 1'b1;
        end
    end

    assign o_valid    = (state_reg == FULL);
    assign can_accept = !o_valid || o_ready;
    assign r0         = !rst && can_accept && !grant && v0;
    assign r1         = !rst && can_accept &&  grant && v1;
    assign accept     = r0 || r1;

    assign sel     = grant ? i1 : i0;
    assign tainted = sel[63] || sel[31] || sticky_hit;
    assign result  = tainted ? ((sel & KEEP_MASK) | FORCE_BITS) : sel;

`ifdef TAINT_STICKY_EN
    logic [1:0] sticky_reg;

    assign sticky_hit = sticky_reg[grant];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sticky
            always_ff @(posedge clk) begin
                if (rst) begin
                    sticky_reg[gi] <= 1'b0;
                end else if (accept && (grant == 1'(gi)) && tainted) begin
                    sticky_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate
`else
    assign sticky_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
            pri_reg   <= 1'b0;
            o         <= 64'h0;
            o_src     <= 1'b0;
            o_taint   <= 1'b0;
            taint_cnt <= '0;
        end else begin
            case (state_reg)
                EMPTY: if (accept) state_reg <= FULL;
                FULL:  if (o_ready && !accept) state_reg <= EMPTY;
                default: state_reg <= EMPTY;
            endcase
            if (accept) begin
                o       <= result;
                o_src   <= grant;
                o_taint <= tainted;
                pri_reg <= ~grant;
                if (tainted && (taint_cnt != CNT_MAX)) begin
                    taint_cnt <= taint_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule
